div_iter_ctrl: RTL
==================

# div_iter_ctrl

Iterative integer-divide controller for the execution stage. It accepts one RISC-V DIV/DIVU/REM/REMU (and W-variant) request at a time and normalises the operands to magnitudes. It then drives an internal chain of 2-bit restoring-division step slices (remanent / dividend-quotient / divisor datapath) once per cycle, applies sign correction and returns a single 64-bit result to writeback. It owns all sequencing, corner-case shortcuts and kill handling for the divider.

## Interface
- STEPS_PER_CYCLE, 1: number of chained 2-bit step slices evaluated per cycle; legal values 1, 2, 4, 8, 16.
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  controller can accept; = (state==IDLE) & ~kill_i.
- dividend_i  in  64  dividend (rs1).
- divisor_i  in  64  divisor (rs2).
- signed_i  in  1  1 = DIV/REM semantics, 0 = DIVU/REMU.
- rem_i  in  1  1 = return remainder, 0 = quotient.
- word_i  in  1  1 = *W op: use operand bits [31:0], sign-extend result from bit 31.
- kill_i  in  1  flush; abandons any operation.
- result_valid_o  out  1  one-cycle result strobe.
- result_o  out  64  result; held until next result.
- busy_o  out  1  state != IDLE.

## Operation
- States: IDLE, ITER, FIX, DONE.
- IDLE: on req_valid_i & req_ready_o, register op flags and operands, then branch:
  - divisor (64-bit, or low 32 for word) == 0 -> DONE with quotient = all-ones and remainder = dividend, sign-extended for word.
  - Otherwise compute magnitudes:
    - Word ops first extend bits [31:0], sign-extending if signed_i, else zero-extending.
    - Record neg_q = signed & (sign(a) ^ sign(b)) and neg_r = signed & sign(a).
  - Load remanent = 0, dividend_quotient = |a| (word: |a| << 32), divisor = |b|.
  - Load counter = N = (word ? 16 : 32) / STEPS_PER_CYCLE, then go to ITER.
- ITER: each cycle, register the outputs of STEPS_PER_CYCLE chained slices and decrement the counter. When the counter is 1, go to FIX.
- FIX: q = dividend_quotient, r = remanent.
  - Select r if rem_i, else q.
  - Negate if the matching neg flag is set (two's complement, 64-bit wrap).
  - Word: sign-extend bit 31.
  - Register into result_o, then go to DONE.
- Signed overflow (most-negative / -1) needs no special path: |a| / 1 negated wraps to a, remainder 0. Word case yields 0xFFFFFFFF80000000.
- DONE: result_valid_o = ~kill_i. Next edge -> IDLE.
- kill_i in any state: next edge -> IDLE. The result strobe is suppressed, result_o is unchanged and no request is accepted that cycle.
- rst_i: next edge -> IDLE, result_o = 0, all internal registers = 0.

## Timing
- Reset values: req_ready_o = 1, result_valid_o = 0, result_o = 0, busy_o = 0.
- Cycle timeline (request accepted at end of cycle 0):
  - cycles 1..N: ITER.
  - cycle N+1: FIX.
  - cycle N+2: result_valid_o high.
- Cycle N+2 examples: 64-bit ops with STEPS_PER_CYCLE=1 -> cycle 34; word ops -> cycle 18.
- Divide-by-zero: result_valid_o high in cycle 1.
- Back-to-back: req_ready_o rises in the cycle after DONE. Minimum issue interval is N+3 cycles (2 for divide-by-zero).
- Request and kill_i in the same IDLE cycle: not accepted.
- kill_i in the DONE cycle: no strobe.
- No output back-pressure: writeback must consume the strobe.
- Operand inputs are sampled only on the accept edge and may change afterwards.

## Test plan
- DIVU 100 / 7, STEPS_PER_CYCLE=1 -> result 14, strobe in cycle 34; REMU same operands -> 2; busy_o high in cycles 1..34.
- DIV -7 / 2 -> 0xFFFF_FFFF_FFFF_FFFD (-3); REM -7 / 2 -> 0xFFFF_FFFF_FFFF_FFFF (-1).
- Divide by zero:
  - DIVU 5 / 0 -> 0xFFFF_FFFF_FFFF_FFFF in cycle 1.
  - REM 5 / 0 -> 5.
  - REMW with dividend 0x1_8000_0000 and divisor 0 -> 0xFFFF_FFFF_8000_0000.
- Overflow and word timing:
  - DIV 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000.
  - REM same operands -> 0.
  - DIVW 0x8000_0000 / 0xFFFF_FFFF -> 0xFFFF_FFFF_8000_0000, strobe in cycle 18.
- Kill:
  - kill_i at cycle 10 of a DIVU -> no strobe, IDLE at cycle 11, next request accepted normally.
  - kill_i with req_valid_i in IDLE -> request not accepted.
- rst_i asserted mid-ITER -> IDLE next cycle, result_o = 0, no strobe. Repeat the first scenario with STEPS_PER_CYCLE=4: strobe in cycle 10.

Source files
------------

// File: rtl/div_iter_ctrl.sv
// Purpose : iterative RISC-V DIV/DIVU/REM/REMU (+W) controller built from chained 2-bit restoring-divide slices.
// Latency : result strobe N+2 cycles after accept, N = (word ? 16 : 32) / STEPS_PER_CYCLE; divide-by-zero strobes 1 cycle after accept.
// Backpr. : one op in flight, req_ready_o = idle & ~kill_i; no output back-pressure, result_o held until next result.
// Ports   : clk_i/rst_i (sync active-high), req_valid_i/req_ready_o handshake, dividend_i/divisor_i operands,
//           signed_i/rem_i/word_i op flags, kill_i flush, result_valid_o/result_o result, busy_o not-idle.
module div_iter_ctrl #(
    parameter int STEPS_PER_CYCLE = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [63:0] dividend_i,
    input  logic [63:0] divisor_i,
    input  logic        signed_i,
    input  logic        rem_i,
    input  logic        word_i,
    input  logic        kill_i,
    output logic        result_valid_o,
    output logic [63:0] result_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

    localparam int N64 = 32 / STEPS_PER_CYCLE;
    localparam int N32 = 16 / STEPS_PER_CYCLE;

    state_t      state_q;
    logic [63:0] rem_q, dq_q, div_q, result_q;
    logic [5:0]  cnt_q;
    logic        negq_q, negr_q, op_rem_q, op_word_q;

    // Operand preparation, evaluated on the request inputs for the accept edge.
    logic [63:0] a_ext, b_ext, a_mag, b_mag, dz_result, dq_init;
    logic        sa, sb, div_zero;

    always_comb begin
        a_ext = dividend_i;
        b_ext = divisor_i;
        if (word_i) begin
            a_ext = signed_i ? {{32{dividend_i[31]}}, dividend_i[31:0]} : {32'b0, dividend_i[31:0]};
            b_ext = signed_i ? {{32{divisor_i[31]}},  divisor_i[31:0]}  : {32'b0, divisor_i[31:0]};
        end
        sa       = signed_i & a_ext[63];
        sb       = signed_i & b_ext[63];
        a_mag    = sa ? -a_ext : a_ext;
        b_mag    = sb ? -b_ext : b_ext;
        div_zero = word_i ? (divisor_i[31:0] == 32'b0) : (divisor_i == 64'b0);
        // Word ops only need 32 bit-steps, so park the magnitude in the upper half.
        dq_init  = word_i ? {a_mag[31:0], 32'b0} : a_mag;
        if (rem_i)
            dz_result = word_i ? {{32{dividend_i[31]}}, dividend_i[31:0]} : dividend_i;
        else
            dz_result = '1;
    end

    // STEPS_PER_CYCLE chained slices, each retiring two restoring-division bits.
    // The partial remainder needs 65 bits: the divisor magnitude can use all 64.
    logic [63:0] rem_nx, dq_nx;
    logic [64:0] trial;

    always_comb begin
        rem_nx = rem_q;
        dq_nx  = dq_q;
        trial  = '0;
        for (int i = 0; i < STEPS_PER_CYCLE * 2; i++) begin
            trial = {rem_nx, dq_nx[63]};
            dq_nx = {dq_nx[62:0], 1'b0};
            if (trial >= {1'b0, div_q}) begin
                trial    = trial - {1'b0, div_q};
                dq_nx[0] = 1'b1;
            end
            rem_nx = trial[63:0];
        end
    end

    // Final selection, sign correction and word sign-extension.
    logic [63:0] fix_sel, fix_val, fix_res;

    always_comb begin
        fix_sel = op_rem_q ? rem_q : dq_q;
        fix_val = (op_rem_q ? negr_q : negq_q) ? -fix_sel : fix_sel;
        fix_res = op_word_q ? {{32{fix_val[31]}}, fix_val[31:0]} : fix_val;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            rem_q     <= '0;
            dq_q      <= '0;
            div_q     <= '0;
            result_q  <= '0;
            cnt_q     <= '0;
            negq_q    <= 1'b0;
            negr_q    <= 1'b0;
            op_rem_q  <= 1'b0;
            op_word_q <= 1'b0;
        end else if (kill_i) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        op_rem_q  <= rem_i;
                        op_word_q <= word_i;
                        negq_q    <= sa ^ sb;
                        negr_q    <= sa;
                        if (div_zero) begin
                            result_q <= dz_result;
                            state_q  <= DONE;
                        end else begin
                            rem_q   <= '0;
                            dq_q    <= dq_init;
                            div_q   <= b_mag;
                            cnt_q   <= word_i ? 6'(N32) : 6'(N64);
                            state_q <= ITER;
                        end
                    end
                end
                ITER: begin
                    rem_q <= rem_nx;
                    dq_q  <= dq_nx;
                    cnt_q <= cnt_q - 6'd1;
                    if (cnt_q == 6'd1)
                        state_q <= FIX;
                end
                FIX: begin
                    result_q <= fix_res;
                    state_q  <= DONE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready_o    = (state_q == IDLE) & ~kill_i;
    assign result_valid_o = (state_q == DONE) & ~kill_i;
    assign busy_o         = (state_q != IDLE);
    assign result_o       = result_q;

endmodule
